// File: rtl/fifo_channel_combiner_if.sv
// -----------------------------------------------------------------------------
// fifo_channel_combiner_if
//
// Purpose: groups the FIFO-facing signals of the N-channel weighted combiner.
//          The input FIFO side (read data, empty flags, pop strobes), the
//          per-channel gain bus and the output FIFO side (write data, full
//          flag, push strobe) travel together as one bundle.
//
// Signals:
//   in_dout   [NUM_CH*DATA_WIDTH]  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   in_empty  [NUM_CH]             per-channel FIFO empty
//   in_rd_en  [NUM_CH]             per-channel FIFO pop
//   gain      [NUM_CH*DATA_WIDTH]  per-channel signed Q(BITS) weight
//   out_din   [DATA_WIDTH]         combined sample
//   out_full                       output FIFO full
//   out_wr_en                      output FIFO push
//
// Modports:
//   master : the combiner itself (drives pops, output data and push)
//   slave  : the surrounding FIFOs / environment
// -----------------------------------------------------------------------------
interface fifo_channel_combiner_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2
);
    logic [NUM_CH*DATA_WIDTH-1:0] in_dout;
    logic [NUM_CH-1:0]            in_empty;
    logic [NUM_CH-1:0]            in_rd_en;
    logic [NUM_CH*DATA_WIDTH-1:0] gain;
    logic [DATA_WIDTH-1:0]        out_din;
    logic                         out_full;
    logic                         out_wr_en;

    modport master (
        input  in_dout,
        input  in_empty,
        input  gain,
        input  out_full,
        output in_rd_en,
        output out_din,
        output out_wr_en
    );

    modport slave (
        output in_dout,
        output in_empty,
        output gain,
        output out_full,
        input  in_rd_en,
        input  out_din,
        input  out_wr_en
    );
endinterface

// File: rtl/fifo_channel_combiner.sv
// -----------------------------------------------------------------------------
// fifo_channel_combiner
//
// Purpose: N-channel signed weighted combiner for the FM datapath. When every
//          input FIFO holds a sample, all channels are popped together, the
//          samples and gains are captured, and sum(gain[k]*x[k]) is formed by
//          a one-channel-per-cycle multiply-accumulate. The sum is dequantized
//          by BITS (rounding toward zero) and pushed into the output FIFO.
//
// Parameters:
//   DATA_WIDTH : sample and gain width (signed two's complement)
//   NUM_CH     : number of input channels (>= 1)
//   BITS       : fraction bits of the gain (1.0 == 1 << BITS)
//
// Ports:
//   clock : system clock
//   reset : asynchronous active-high reset
//   bus   : fifo_channel_combiner_if.master (FIFO handshakes, gains, result)
//   busy  : high whenever the engine is not idle
//
// Optional feature (macro SATURATE_EN):
//   defined   : the result clamps to the signed DATA_WIDTH range and an
//               internal sat_hit pulses in the cycle the clamp is applied
//   undefined : the result wraps (truncated to DATA_WIDTH bits)
// -----------------------------------------------------------------------------
module fifo_channel_combiner #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int BITS       = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    fifo_channel_combiner_if.master bus,
    output logic                    busy
);

    // Accumulator headroom: NUM_CH full-scale products cannot overflow it.
    localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_CH);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]        LAST_CNT   = CNT_W'(NUM_CH - 1);
    // Bias added to negative sums so the arithmetic shift truncates toward zero.
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'((64'd1 << BITS) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MAC   = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    state_t                        state_r;
    state_t                        state_s;
    logic [CNT_W-1:0]              cnt_r;
    logic signed [ACC_W-1:0]       acc_r;
    logic signed [DATA_WIDTH-1:0]  result_r;
    logic signed [DATA_WIDTH-1:0]  x_r [NUM_CH];
    logic signed [DATA_WIDTH-1:0]  g_r [NUM_CH];

    logic                          all_ready_s;
    logic                          mac_last_s;
    logic signed [PROD_W-1:0]      prod_s;
    logic signed [ACC_W-1:0]       acc_sum_s;
    logic signed [DATA_WIDTH-1:0]  result_s;
    logic [NUM_CH-1:0]             rd_en_s;
    logic                          wr_en_s;
    logic [DATA_WIDTH-1:0]         out_din_s;

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic sat_hit_s;

    // Round toward zero, then clamp into the signed DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] dequant(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] q;
        if (acc[ACC_W-1]) begin
            q = (acc + ROUND_BIAS) >>> BITS;
        end else begin
            q = acc >>> BITS;
        end
        if (q > SAT_MAX) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (q < SAT_MIN) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return q[DATA_WIDTH-1:0];
        end
    endfunction

    // True when the rounded sum lies outside the signed DATA_WIDTH range.
    function automatic logic needs_clamp(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] q;
        if (acc[ACC_W-1]) begin
            q = (acc + ROUND_BIAS) >>> BITS;
        end else begin
            q = acc >>> BITS;
        end
        return (q > SAT_MAX) || (q < SAT_MIN);
    endfunction
`else
    // Round toward zero, then wrap into DATA_WIDTH bits.
    function automatic logic signed [DATA_WIDTH-1:0] dequant(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] q;
        if (acc[ACC_W-1]) begin
            q = (acc + ROUND_BIAS) >>> BITS;
        end else begin
            q = acc >>> BITS;
        end
        return q[DATA_WIDTH-1:0];
    endfunction
`endif

    // Pop is gated by reset so no FIFO is drained while the block is held in reset.
    assign all_ready_s = ~(|bus.in_empty) & ~reset;
    assign mac_last_s  = (cnt_r == LAST_CNT);

    // Multiply-accumulate datapath for the channel selected by the counter.
    always_comb begin
        prod_s    = PROD_W'(x_r[cnt_r]) * PROD_W'(g_r[cnt_r]);
        acc_sum_s = acc_r + ACC_W'(prod_s);
        result_s  = dequant(acc_sum_s);
    end

`ifdef SATURATE_EN
    // Clamp indicator, valid in the cycle the result register is loaded.
    always_comb begin
        if ((state_r == S_MAC) && mac_last_s) begin
            sat_hit_s = needs_clamp(acc_sum_s);
        end else begin
            sat_hit_s = 1'b0;
        end
    end
`endif

    // Next-state and handshake decode.
    always_comb begin
        state_s = state_r;
        rd_en_s = '0;
        wr_en_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (all_ready_s) begin
                    rd_en_s = {NUM_CH{1'b1}};
                    state_s = S_MAC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MAC: begin
                if (mac_last_s) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_MAC;
                end
            end
            S_WRITE: begin
                if (!bus.out_full) begin
                    wr_en_s = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WRITE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output data is only presented while a result is waiting to be pushed.
    always_comb begin
        if (state_r == S_WRITE) begin
            out_din_s = result_r;
        end else begin
            out_din_s = '0;
        end
    end

    assign bus.in_rd_en  = rd_en_s;
    assign bus.out_wr_en = wr_en_s;
    assign bus.out_din   = out_din_s;
    assign busy          = (state_r != S_IDLE);

    // State, operand capture, accumulator and result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            acc_r    <= '0;
            result_r <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                x_r[k] <= '0;
                g_r[k] <= '0;
            end
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (all_ready_s) begin
                        // Gains are frozen here so later changes cannot disturb this sample.
                        for (int k = 0; k < NUM_CH; k++) begin
                            x_r[k] <= bus.in_dout[k*DATA_WIDTH +: DATA_WIDTH];
                            g_r[k] <= bus.gain[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        acc_r <= '0;
                        cnt_r <= '0;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_sum_s;
                    if (mac_last_s) begin
                        cnt_r    <= '0;
                        result_r <= result_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_channel_combiner.sv
// -----------------------------------------------------------------------------
// tb_fifo_channel_combiner
//
// Directed bench for the weighted combiner. A two-channel instance covers the
// arithmetic, gating and backpressure scenarios; a four-channel instance covers
// reset in the middle of the accumulate phase. Expected values are computed by
// hand from the Q10 gains. Inputs are driven and outputs sampled around the
// falling clock edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_channel_combiner;

    logic clock;
    logic reset;
    logic busy2;
    logic busy4;

    int tests_run;
    int tests_failed;

    fifo_channel_combiner_if #(.DATA_WIDTH(32), .NUM_CH(2)) bus2 ();
    fifo_channel_combiner_if #(.DATA_WIDTH(32), .NUM_CH(4)) bus4 ();

    fifo_channel_combiner #(.DATA_WIDTH(32), .NUM_CH(2), .BITS(10)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2),
        .busy  (busy2)
    );

    fifo_channel_combiner #(.DATA_WIDTH(32), .NUM_CH(4), .BITS(10)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4),
        .busy  (busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One two-channel transaction: pops at cycle 0, returns push cycle and data.
    task automatic xact2(input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] g0, input logic [31:0] g1,
                         output logic [31:0] dout, output int lat, output int pops);
        @(negedge clock);
        bus2.in_dout  = {x1, x0};
        bus2.gain     = {g1, g0};
        bus2.in_empty = 2'b00;
        lat  = -1;
        pops = 0;
        dout = 32'h0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus2.in_rd_en != 2'b00) pops++;
            if (bus2.out_wr_en) begin
                dout = bus2.out_din;
                lat  = c;
            end
            @(negedge clock);
            bus2.in_empty = 2'b11;
            if (lat >= 0) break;
        end
    endtask

    // One four-channel transaction, same timing reference as xact2.
    task automatic xact4(input logic [127:0] xs, input logic [127:0] gs,
                         output logic [31:0] dout, output int lat);
        @(negedge clock);
        bus4.in_dout  = xs;
        bus4.gain     = gs;
        bus4.in_empty = 4'b0000;
        lat  = -1;
        dout = 32'h0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus4.out_wr_en) begin
                dout = bus4.out_din;
                lat  = c;
            end
            @(negedge clock);
            bus4.in_empty = 4'b1111;
            if (lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus2.in_dout  = {32'd7, 32'd5};
        bus2.gain     = {32'd1024, 32'd1024};
        bus2.in_empty = 2'b00;
        bus2.out_full = 1'b0;
        bus4.in_dout  = '0;
        bus4.gain     = '0;
        bus4.in_empty = 4'b0000;
        bus4.out_full = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        tests_run++;
        if (bus2.in_rd_en !== 2'b00) begin tests_failed++; $display("FAIL reset_rd_en2: got %b expected 00", bus2.in_rd_en); end
        tests_run++;
        if (bus4.in_rd_en !== 4'b0000) begin tests_failed++; $display("FAIL reset_rd_en4: got %b expected 0000", bus4.in_rd_en); end
        tests_run++;
        if (bus2.out_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", bus2.out_wr_en); end
        tests_run++;
        if (bus2.out_din !== 32'h0) begin tests_failed++; $display("FAIL reset_din: got %h expected 0", bus2.out_din); end
        tests_run++;
        if (busy2 !== 1'b0 || busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy2, busy4); end
        @(negedge clock);
        bus2.in_empty = 2'b11;
        bus4.in_empty = 4'b1111;
        reset         = 1'b0;
    endtask

    task automatic test_basic_sum();
        logic [31:0] d;
        int          lat;
        int          pops;
        xact2(32'd5, 32'd7, 32'd1024, 32'd1024, d, lat, pops);
        tests_run++;
        if (d !== 32'd12) begin tests_failed++; $display("FAIL basic_sum: got %0d expected 12", d); end
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        tests_run++;
        if (pops !== 1) begin tests_failed++; $display("FAIL basic_pop_count: got %0d expected 1", pops); end
        #1;
        tests_run++;
        if (busy2 !== 1'b0 || bus2.out_din !== 32'h0) begin tests_failed++; $display("FAIL basic_idle_after: busy %b din %h expected 0/0", busy2, bus2.out_din); end
    endtask

    task automatic test_negative_rounding();
        logic [31:0] d;
        int          lat;
        int          pops;
        // -3 * 0.5 = -1.5 -> -1
        xact2(-32'sd3, 32'd0, 32'd512, 32'd0, d, lat, pops);
        tests_run++;
        if (d !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL neg_round_half: got %h expected ffffffff", d); end
        // 4 - 10 = -6
        xact2(32'd4, 32'd10, 32'd1024, -32'sd1024, d, lat, pops);
        tests_run++;
        if (d !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL neg_diff: got %h expected fffffffa", d); end
        // 3 * 0.5 = 1.5 -> 1
        xact2(32'd3, 32'd0, 32'd512, 32'd0, d, lat, pops);
        tests_run++;
        if (d !== 32'd1) begin tests_failed++; $display("FAIL pos_round_half: got %h expected 1", d); end
        // -4 * 0.25 = -1 exactly
        xact2(-32'sd4, 32'd0, 32'd256, 32'd0, d, lat, pops);
        tests_run++;
        if (d !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL neg_exact: got %h expected ffffffff", d); end
    endtask

    task automatic test_empty_gating();
        logic [31:0] d;
        int          lat;
        int          pops;
        int          bad;
        bad = 0;
        @(negedge clock);
        bus2.in_dout  = {32'd9, 32'd9};
        bus2.in_empty = 2'b10;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus2.in_rd_en !== 2'b00 || busy2 !== 1'b0) bad++;
            @(negedge clock);
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL empty_gating: got %0d bad cycles expected 0", bad); end
        // 100*1 + (-1)*2 = 98
        xact2(32'd100, -32'sd1, 32'd1024, 32'd2048, d, lat, pops);
        tests_run++;
        if (lat !== 3 || pops !== 1) begin tests_failed++; $display("FAIL empty_release: lat %0d pops %0d expected 3/1", lat, pops); end
        tests_run++;
        if (d !== 32'd98) begin tests_failed++; $display("FAIL empty_release_value: got %0d expected 98", d); end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        @(negedge clock);
        bus2.out_full = 1'b1;
        bus2.in_dout  = {-32'sd2, 32'd9};
        bus2.gain     = {32'd3072, 32'd1024};
        bus2.in_empty = 2'b00;
        #1;
        tests_run++;
        if (bus2.in_rd_en !== 2'b11) begin tests_failed++; $display("FAIL bp_pop: got %b expected 11", bus2.in_rd_en); end
        @(negedge clock);
        bus2.in_empty = 2'b11;
        // Gain change after capture must not affect the result.
        bus2.gain     = {32'd0, 32'd0};
        repeat (2) @(negedge clock);
        // Fresh data available during the stall must not be popped.
        bus2.in_empty = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus2.out_wr_en !== 1'b0 || bus2.out_din !== 32'd3 || bus2.in_rd_en !== 2'b00 || busy2 !== 1'b1) bad++;
            @(negedge clock);
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL bp_stall: got %0d bad cycles expected 0", bad); end
        bus2.out_full = 1'b0;
        bus2.in_empty = 2'b11;
        #1;
        tests_run++;
        if (bus2.out_wr_en !== 1'b1 || bus2.out_din !== 32'd3) begin tests_failed++; $display("FAIL bp_release: wr %b din %0d expected 1/3", bus2.out_wr_en, bus2.out_din); end
        @(negedge clock);
        #1;
        tests_run++;
        if (bus2.out_wr_en !== 1'b0 || busy2 !== 1'b0) begin tests_failed++; $display("FAIL bp_single_push: wr %b busy %b expected 0/0", bus2.out_wr_en, busy2); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] exp_pos;
        logic [31:0] exp_neg;
        int          lat;
        int          pops;
`ifdef SATURATE_EN
        exp_pos = 32'h7FFFFFFF;
        exp_neg = 32'h80000000;
`else
        exp_pos = 32'hFFFFFFFE;
        exp_neg = 32'h00000000;
`endif
        xact2(32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1024, 32'd1024, d, lat, pops);
        tests_run++;
        if (d !== exp_pos) begin tests_failed++; $display("FAIL overflow_pos: got %h expected %h", d, exp_pos); end
        xact2(32'h80000000, 32'h80000000, 32'd1024, 32'd1024, d, lat, pops);
        tests_run++;
        if (d !== exp_neg) begin tests_failed++; $display("FAIL overflow_neg: got %h expected %h", d, exp_neg); end
    endtask

    task automatic test_back_to_back();
        int pop_cnt;
        int push_cnt;
        int second_pop;
        pop_cnt    = 0;
        push_cnt   = 0;
        second_pop = -1;
        @(negedge clock);
        bus2.in_dout  = {32'd2, 32'd1};
        bus2.gain     = {32'd1024, 32'd1024};
        bus2.in_empty = 2'b00;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus2.in_rd_en == 2'b11) begin
                if (pop_cnt == 1) second_pop = c;
                pop_cnt++;
            end
            if (bus2.out_wr_en) begin
                push_cnt++;
                tests_run++;
                if (bus2.out_din !== 32'd3) begin tests_failed++; $display("FAIL b2b_value: got %0d expected 3", bus2.out_din); end
            end
            @(negedge clock);
        end
        bus2.in_empty = 2'b11;
        tests_run++;
        if (pop_cnt !== 2 || second_pop !== 4) begin tests_failed++; $display("FAIL b2b_pops: got %0d pops second at %0d expected 2 at 4", pop_cnt, second_pop); end
        tests_run++;
        if (push_cnt !== 2) begin tests_failed++; $display("FAIL b2b_pushes: got %0d expected 2", push_cnt); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_mac();
        logic [31:0] d;
        int          lat;
        int          pushes;
        @(negedge clock);
        bus4.in_dout  = {32'd4, 32'd3, 32'd2, 32'd1};
        bus4.gain     = {32'd1024, 32'd1024, 32'd1024, 32'd1024};
        bus4.in_empty = 4'b0000;
        #1;
        tests_run++;
        if (bus4.in_rd_en !== 4'b1111) begin tests_failed++; $display("FAIL mid_pop: got %b expected 1111", bus4.in_rd_en); end
        @(negedge clock);
        bus4.in_empty = 4'b1111;
        @(negedge clock);
        #1;
        tests_run++;
        if (busy4 !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b expected 1", busy4); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus4.in_rd_en !== 4'b0000 || bus4.out_wr_en !== 1'b0 || bus4.out_din !== 32'h0 || busy4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: rd %b wr %b din %h busy %b expected all 0", bus4.in_rd_en, bus4.out_wr_en, bus4.out_din, busy4);
        end
        @(negedge clock);
        reset  = 1'b0;
        pushes = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus4.out_wr_en !== 1'b0) pushes++;
            @(negedge clock);
        end
        tests_run++;
        if (pushes !== 0) begin tests_failed++; $display("FAIL mid_no_push: got %0d pushes expected 0", pushes); end
        // -5*1 + 6*2 + 7*(-1) + 8*0.5 = 4
        xact4({32'd8, 32'd7, 32'd6, -32'sd5}, {32'd512, -32'sd1024, 32'd2048, 32'd1024}, d, lat);
        tests_run++;
        if (d !== 32'd4) begin tests_failed++; $display("FAIL mid_recover_value: got %0d expected 4", d); end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL mid_recover_latency: got %0d expected 5", lat); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_sum();
        test_negative_rounding();
        test_empty_gating();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
